// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the round-robin arbitrating multiplexer.
package rr_arb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCH   = 5;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle: NCH upstream channels in, one registered output channel out.
interface rr_arb_mux_if
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = 3
);

    logic [NCH-1:0]       ch_enable;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_ready;

    modport slave (
        input  ch_enable, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output ch_enable, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_arb_mux_grant.sv
// Combinational grant finder: first request at or above ptr, wrapping modulo NCH.
module rr_grant
    import rr_arb_pkg::*;
#(
    parameter int NCH  = DEF_NCH,
    parameter int SELW = 3
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] grant_o,
    output logic            any_o
);

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    logic [SELW-1:0]  off;
    logic [SELW:0]    sum;
    logic             hit;

    always_comb begin
        // Rotating the doubled vector puts channel ptr at bit 0 so a plain LSB-first search wraps.
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[NCH-1:0];
        off = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rot[i] && !hit) begin
                off = SELW'(i);
                hit = 1'b1;
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (SELW+1)'(NCH)) begin
            sum = sum - (SELW+1)'(NCH);
        end
        grant_o = sum[SELW-1:0];
        any_o   = |req_i;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux with one registered output stage; round-robin or fixed priority.
module rr_arb_mux
    import rr_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NCH     = DEF_NCH,
    parameter int SELW    = 3,
    parameter int RR_MODE = 1
) (
    input  logic         clock,
    input  logic         reset,
    rr_arb_mux_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NCH-1:0]   req;
    logic [SELW-1:0]  search_ptr;
    logic [SELW-1:0]  grant;
    logic             any;
    logic [NCH-1:0]   grant_oh;
    logic [WIDTH-1:0] sel_data;
    logic             can_load;
    logic             load;

    assign req        = bus.in_valid & bus.ch_enable;
    assign search_ptr = (RR_MODE != 0) ? rr_ptr_q : '0;

    rr_grant #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_grant (
        .req_i   (req),
        .ptr_i   (search_ptr),
        .grant_o (grant),
        .any_o   (any)
    );

    // Reset blocks the upstream handshake so nothing is accepted in a reset cycle.
    assign can_load = (state_q == ST_EMPTY) || bus.out_ready;
    assign load     = can_load && any && !reset;
    assign grant_oh = any ? (NCH'(1) << grant) : '0;

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            sel_data = sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_oh[i]}});
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!load && bus.out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (load) begin
            out_data_d = sel_data;
            out_sel_d  = grant;
            if (RR_MODE != 0) begin
                rr_ptr_d = (grant == SELW'(NCH-1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_sel_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = load ? grant_oh : '0;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule
